// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the memory/writeback stage.
package mem_access_unit_pkg;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // funct3 access size/sign encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    // Misaligned, illegal-encoding or conflicting access; never set for non-memory ops.
    function automatic logic access_fault(input logic       memren,
                                          input logic       memwren,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic f;
        f = 1'b0;
        if (memren && memwren) begin
            f = 1'b1;
        end else if (memren) begin
            if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) f = 1'b1;
        end else if (memwren) begin
            if (funct3 >= 3'd3) f = 1'b1;
        end
        if (memren || memwren) begin
            // funct3[1:0] carries the size for both signed and unsigned loads
            if (funct3[1:0] == 2'd1 && addr_lo[0]) f = 1'b1;
            if (funct3[1:0] == 2'd2 && addr_lo != 2'd0) f = 1'b1;
        end
        return f;
    endfunction

    // Byte-lane enables for an access of the given size at the given offset.
    function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'd0:    be = 4'b0001 << addr_lo;
            2'd1:    be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/halfword of a load word and sign- or zero-extends it.
module load_align
    import mem_access_unit_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    output logic [DWIDTH-1:0] ext
);

    logic [7:0]  lane;
    logic [15:0] half;

    // Lane selection and extension by access size/sign
    always_comb begin
        lane = rdata[{addr_lo, 3'b000} +: 8];
        half = rdata[{addr_lo[1], 4'b0000} +: 16];
        ext  = rdata;
        case (funct3)
            F3_LB:   ext = {{(DWIDTH-8){lane[7]}}, lane};
            F3_LBU:  ext = {{(DWIDTH-8){1'b0}}, lane};
            F3_LH:   ext = {{(DWIDTH-16){half[15]}}, half};
            F3_LHU:  ext = {{(DWIDTH-16){1'b0}}, half};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory/writeback stage: one data-memory request per load/store, then one
// writeback beat to the register file. One instruction in flight at a time.
//
// state | meaning
// IDLE  | ready for a new instruction; captures inputs on valid_i
// REQ   | memory request presented, held until mem_req_ready_i
// WAIT  | load issued, waiting for mem_rsp_valid_i
// WB    | single-cycle writeback beat
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic              regwren_i,
    input  logic [1:0]        wbsel_i,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        rd_i,
    input  logic [AWIDTH-1:0] alu_res_i,
    input  logic [DWIDTH-1:0] rs2_data_i,
    input  logic [AWIDTH-1:0] pc_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_regwren_o,
    output logic [4:0]        wb_rd_o,
    output logic [DWIDTH-1:0] wb_data_o,
    output logic              fault_o
);

    state_t            state;
    logic [AWIDTH-1:0] alu_q;
    logic [AWIDTH-1:0] pc_q;
    logic [2:0]        funct3_q;
    logic [1:0]        wbsel_q;
    logic [4:0]        rd_q;
    logic              regwren_q;
    logic              store_q;

    logic              access_in;
    logic              fault_in;
    logic [3:0]        be_in;
    logic [DWIDTH-1:0] wdata_in;
    logic [DWIDTH-1:0] load_ext;

    function automatic logic [DWIDTH-1:0] wb_mux(input logic [1:0]        sel,
                                                 input logic [AWIDTH-1:0] alu,
                                                 input logic [AWIDTH-1:0] pc,
                                                 input logic [DWIDTH-1:0] ld);
        logic [AWIDTH-1:0] pc4;
        logic [DWIDTH-1:0] v;
        pc4 = pc + AWIDTH'(4);
        case (sel)
            WB_MEM:  v = ld;
            WB_PC4:  v = DWIDTH'(pc4);
            default: v = DWIDTH'(alu);
        endcase
        return v;
    endfunction

    // Decode of the incoming instruction: fault check, lane enables, replicated store data
    always_comb begin
        access_in = memren_i || memwren_i;
        fault_in  = access_fault(memren_i, memwren_i, funct3_i, alu_res_i[1:0]);
        be_in     = byte_enables(funct3_i, alu_res_i[1:0]);
        case (funct3_i[1:0])
            2'd0:    wdata_in = {4{rs2_data_i[7:0]}};
            2'd1:    wdata_in = {2{rs2_data_i[15:0]}};
            default: wdata_in = rs2_data_i;
        endcase
    end

    load_align #(.DWIDTH(DWIDTH)) u_load_align (
        .rdata   (mem_rdata_i),
        .addr_lo (alu_q[1:0]),
        .funct3  (funct3_q),
        .ext     (load_ext)
    );

    // Sequencing FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ready_o         <= 1'b1;
            alu_q           <= '0;
            pc_q            <= '0;
            funct3_q        <= '0;
            wbsel_q         <= '0;
            rd_q            <= '0;
            regwren_q       <= 1'b0;
            store_q         <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_addr_o      <= '0;
            mem_we_o        <= 1'b0;
            mem_be_o        <= '0;
            mem_wdata_o     <= '0;
            wb_valid_o      <= 1'b0;
            wb_regwren_o    <= 1'b0;
            wb_rd_o         <= '0;
            wb_data_o       <= '0;
            fault_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        ready_o   <= 1'b0;
                        alu_q     <= alu_res_i;
                        pc_q      <= pc_i;
                        funct3_q  <= funct3_i;
                        wbsel_q   <= wbsel_i;
                        rd_q      <= rd_i;
                        regwren_q <= regwren_i;
                        store_q   <= memwren_i;
                        if (access_in && !fault_in) begin
                            state           <= REQ;
                            mem_req_valid_o <= 1'b1;
                            mem_addr_o      <= {alu_res_i[AWIDTH-1:2], 2'b00};
                            mem_we_o        <= memwren_i;
                            mem_be_o        <= be_in;
                            mem_wdata_o     <= memwren_i ? wdata_in : '0;
                        end else begin
                            state        <= WB;
                            wb_valid_o   <= 1'b1;
                            wb_regwren_o <= regwren_i && !fault_in && (rd_i != 5'd0);
                            wb_rd_o      <= rd_i;
                            wb_data_o    <= wb_mux(wbsel_i, alu_res_i, pc_i, '0);
                            fault_o      <= fault_in;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        mem_addr_o      <= '0;
                        mem_we_o        <= 1'b0;
                        mem_be_o        <= '0;
                        mem_wdata_o     <= '0;
                        if (store_q) begin
                            state        <= WB;
                            wb_valid_o   <= 1'b1;
                            wb_regwren_o <= 1'b0;
                            wb_rd_o      <= rd_q;
                            wb_data_o    <= wb_mux(wbsel_q, alu_q, pc_q, '0);
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid_i) begin
                        state        <= WB;
                        wb_valid_o   <= 1'b1;
                        wb_regwren_o <= regwren_q && (rd_q != 5'd0);
                        wb_rd_o      <= rd_q;
                        wb_data_o    <= wb_mux(wbsel_q, alu_q, pc_q, load_ext);
                    end
                end
                WB: begin
                    state        <= IDLE;
                    ready_o      <= 1'b1;
                    wb_valid_o   <= 1'b0;
                    wb_regwren_o <= 1'b0;
                    wb_rd_o      <= '0;
                    wb_data_o    <= '0;
                    fault_o      <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: scoreboard of expected writeback beats plus
// directed and randomized load/store/ALU scenarios.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o;
    logic        memren_i, memwren_i, regwren_i;
    logic [1:0]  wbsel_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic [31:0] alu_res_i, rs2_data_i, pc_i;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o, wb_regwren_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        fault_o;

    always #5 clk = ~clk;

    mem_access_unit #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .memren_i(memren_i), .memwren_i(memwren_i), .regwren_i(regwren_i),
        .wbsel_i(wbsel_i), .funct3_i(funct3_i), .rd_i(rd_i),
        .alu_res_i(alu_res_i), .rs2_data_i(rs2_data_i), .pc_i(pc_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o),
        .wb_regwren_o(wb_regwren_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .fault_o(fault_o)
    );

    // Reference load extraction shared with the design
    logic [31:0] ref_rdata, ref_ext;
    logic [1:0]  ref_addr;
    logic [2:0]  ref_f3;
    load_align #(.DWIDTH(32)) u_ref (.rdata(ref_rdata), .addr_lo(ref_addr), .funct3(ref_f3), .ext(ref_ext));

    typedef struct {
        logic        regwren;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fault;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int tests_run = 0;
    int fails = 0;
    int wb_count = 0;
    int req_accepts = 0;
    int req_valid_cycles = 0;

    logic        hold_prev = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    logic        h_we;

    function automatic logic exp_fault(input logic mr, input logic mw, input logic [2:0] f3, input logic [1:0] a);
        if (!mr && !mw) return 1'b0;
        if (mr && mw) return 1'b1;
        if (mr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        if (mw && f3 >= 3'd3) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] sh;
        logic [15:0] h;
        sh = w >> (a * 8);
        h  = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd4:    return {24'h0, sh[7:0]};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'd0, 3'd4: return (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 : (a == 2'd2) ? 4'b0100 : 4'b1000;
            3'd1, 3'd5: return a[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'd1:    return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    // Track whether a request was stalled at the last edge, plus accepted handshakes
    always @(posedge clk) begin
        hold_prev <= rst_n && mem_req_valid_o && !mem_req_ready_i;
        h_addr    <= mem_addr_o;
        h_wdata   <= mem_wdata_o;
        h_be      <= mem_be_o;
        h_we      <= mem_we_o;
        if (rst_n && mem_req_valid_o && mem_req_ready_i) req_accepts <= req_accepts + 1;
    end

    // Request stability and writeback scoreboard checks, away from the active edge
    always @(negedge clk) begin
        if (rst_n && mem_req_valid_o) req_valid_cycles++;
        if (rst_n && hold_prev) begin
            tests_run++;
            if (mem_req_valid_o !== 1'b1 || mem_addr_o !== h_addr || mem_wdata_o !== h_wdata ||
                mem_be_o !== h_be || mem_we_o !== h_we) begin
                fails++;
                $display("FAIL req_stable: valid=%b addr=%h be=%b we=%b wdata=%h, required valid=1 addr=%h be=%b we=%b wdata=%h",
                         mem_req_valid_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o, h_addr, h_be, h_we, h_wdata);
            end
        end
        if (rst_n && wb_valid_o) begin
            wb_count++;
            tests_run++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: beat rd=%0d data=%h with empty scoreboard, required no beat", wb_rd_o, wb_data_o);
            end else begin
                wb_exp_t e;
                e = sb_q.pop_front();
                if (wb_regwren_o !== e.regwren || wb_rd_o !== e.rd || fault_o !== e.fault ||
                    (!e.fault && wb_data_o !== e.data)) begin
                    fails++;
                    $display("FAIL wb_beat: regwren=%b rd=%0d data=%h fault=%b, required regwren=%b rd=%0d data=%h fault=%b",
                             wb_regwren_o, wb_rd_o, wb_data_o, fault_o, e.regwren, e.rd, e.data, e.fault);
                end
            end
        end
    end

    // Drive one instruction through the stage, play the memory side with the given
    // stall/delay, and report the cycle (relative to acceptance) of the writeback beat.
    task automatic run_instr(input logic mr, input logic mw, input logic rw, input logic [1:0] wbsel,
                             input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                             input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] rdata,
                             input int stall, input int delay, output int lat);
        wb_exp_t e;
        logic    flt;
        int      cyc;
        int      k;
        flt = exp_fault(mr, mw, f3, alu[1:0]);
        e.fault   = flt;
        e.rd      = rd;
        e.regwren = rw && !flt && !mw && (rd != 5'd0);
        case (wbsel)
            2'd1:    e.data = exp_load(rdata, alu[1:0], f3);
            2'd2:    e.data = pc + 32'd4;
            default: e.data = alu;
        endcase
        @(negedge clk);
        k = 0;
        while (!ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ready_o) begin
            tests_run++;
            fails++;
            $display("FAIL ready_timeout: ready_o=%b, required 1", ready_o);
        end
        sb_q.push_back(e);
        valid_i = 1'b1; memren_i = mr; memwren_i = mw; regwren_i = rw; wbsel_i = wbsel;
        funct3_i = f3; rd_i = rd; alu_res_i = alu; rs2_data_i = rs2; pc_i = pc;
        mem_req_ready_i = 1'b0;
        @(negedge clk);
        cyc = 1;
        valid_i = 1'b0; alu_res_i = $urandom; rs2_data_i = $urandom; pc_i = $urandom;
        rd_i = 5'($urandom); wbsel_i = 2'($urandom); funct3_i = 3'($urandom);
        tests_run++;
        if ((mr || mw) && !flt) begin
            if (mem_req_valid_o !== 1'b1 || mem_addr_o !== {alu[31:2], 2'b00} || mem_we_o !== mw ||
                mem_be_o !== exp_be(f3, alu[1:0]) || (mw && mem_wdata_o !== exp_wdata(f3, rs2))) begin
                fails++;
                $display("FAIL req_fields: valid=%b addr=%h we=%b be=%b wdata=%h, required valid=1 addr=%h we=%b be=%b wdata=%h",
                         mem_req_valid_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
                         {alu[31:2], 2'b00}, mw, exp_be(f3, alu[1:0]), exp_wdata(f3, rs2));
            end
            repeat (stall) begin
                @(negedge clk);
                cyc++;
            end
            mem_req_ready_i = 1'b1;
            @(negedge clk);
            cyc++;
            mem_req_ready_i = 1'b0;
            if (mr) begin
                repeat (delay) begin
                    @(negedge clk);
                    cyc++;
                end
                mem_rsp_valid_i = 1'b1;
                mem_rdata_i = rdata;
                @(negedge clk);
                cyc++;
                mem_rsp_valid_i = 1'b0;
                mem_rdata_i = $urandom;
            end
        end else begin
            if (mem_req_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL no_req: mem_req_valid_o=%b, required 0", mem_req_valid_o);
            end
        end
        k = 0;
        while (!wb_valid_o && k < 30) begin
            @(negedge clk);
            cyc++;
            k++;
        end
        if (!wb_valid_o) begin
            tests_run++;
            fails++;
            $display("FAIL wb_timeout: wb_valid_o=%b after %0d cycles, required 1", wb_valid_o, cyc);
            sb_q.delete();
        end
        lat = cyc;
        @(negedge clk);
        tests_run++;
        if (wb_valid_o !== 1'b0 || ready_o !== 1'b1) begin
            fails++;
            $display("FAIL wb_one_cycle: wb_valid_o=%b ready_o=%b, required 0 and 1", wb_valid_o, ready_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_i = 0; memren_i = 0; memwren_i = 0; regwren_i = 0; wbsel_i = 0; funct3_i = 0;
        rd_i = 0; alu_res_i = 0; rs2_data_i = 0; pc_i = 0;
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rdata_i = 0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ready_o !== 1'b1 || mem_req_valid_o !== 1'b0 || wb_valid_o !== 1'b0 || fault_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: ready=%b req=%b wb=%b fault=%b, required 1 0 0 0", ready_o, mem_req_valid_o, wb_valid_o, fault_o);
        end
        tests_run++;
        if (mem_addr_o !== 0 || mem_be_o !== 0 || mem_wdata_o !== 0 || mem_we_o !== 0 ||
            wb_data_o !== 0 || wb_rd_o !== 0 || wb_regwren_o !== 0) begin
            fails++;
            $display("FAIL reset_data: addr=%h be=%b wdata=%h we=%b wbdata=%h rd=%0d regwren=%b, required all 0",
                     mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o, wb_data_o, wb_rd_o, wb_regwren_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_ops();
        int lat;
        logic [1:0]  sel [4] = '{2'd0, 2'd2, 2'd2, 2'd3};
        logic [31:0] alu [4] = '{32'h0000_1234, 32'h5, 32'h7, 32'h0000_DEAD};
        logic [31:0] pc  [4] = '{32'h0, 32'h0000_0100, 32'hFFFF_FFFC, 32'h40};
        logic [4:0]  rd  [4] = '{5'd5, 5'd1, 5'd31, 5'd0};
        for (int i = 0; i < 4; i++) begin
            run_instr(0, 0, 1, sel[i], 3'd0, rd[i], alu[i], 32'h0, pc[i], 32'h0, 0, 0, lat);
            tests_run++;
            if (lat !== 1) begin
                fails++;
                $display("FAIL alu_latency[%0d]: wb after %0d cycles, required 1", i, lat);
            end
        end
    endtask

    task automatic test_store();
        int lat;
        logic [2:0]  f3  [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
        logic [31:0] adr [4] = '{32'h0000_1003, 32'h0000_1002, 32'h0000_1004, 32'h0000_1000};
        logic [31:0] dat [4] = '{32'h1234_56AB, 32'h0000_BEEF, 32'hCAFE_F00D, 32'hFFFF_FF5A};
        for (int i = 0; i < 4; i++) begin
            run_instr(0, 1, 0, 2'd0, f3[i], 5'd9, adr[i], dat[i], 32'h80, 32'h0, 0, 0, lat);
            tests_run++;
            if (lat !== 2) begin
                fails++;
                $display("FAIL store_latency[%0d]: wb after %0d cycles, required 2", i, lat);
            end
        end
    endtask

    task automatic test_load();
        int lat;
        logic [2:0]  f3  [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd2};
        logic [31:0] adr [6] = '{32'h2002, 32'h2002, 32'h2002, 32'h2002, 32'h2000, 32'h2004};
        logic [31:0] dat [6] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000, 32'h89AB_CDEF, 32'h1111_2222};
        logic [4:0]  rd  [6] = '{5'd7, 5'd8, 5'd10, 5'd11, 5'd12, 5'd0};
        logic [31:0] want [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h89AB_CDEF, 32'h1111_2222};
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (exp_load(dat[i], adr[i][1:0], f3[i]) !== want[i]) begin
                fails++;
                $display("FAIL load_model[%0d]: model=%h, required %h", i, exp_load(dat[i], adr[i][1:0], f3[i]), want[i]);
            end
            run_instr(1, 0, 1, 2'd1, f3[i], rd[i], adr[i], 32'h0, 32'h0, dat[i], 0, 0, lat);
            tests_run++;
            if (lat !== 3) begin
                fails++;
                $display("FAIL load_latency[%0d]: wb after %0d cycles, required 3", i, lat);
            end
        end
    endtask

    task automatic test_fault();
        int lat;
        int acc0, vc0;
        logic        mr  [8] = '{1, 1, 1, 1, 0, 0, 1, 0};
        logic        mw  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        logic [2:0]  f3  [8] = '{3'd2, 3'd5, 3'd3, 3'd6, 3'd3, 3'd4, 3'd2, 3'd1};
        logic [31:0] adr [8] = '{32'h3002, 32'h3001, 32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h3003};
        acc0 = req_accepts;
        vc0  = req_valid_cycles;
        for (int i = 0; i < 8; i++) begin
            run_instr(mr[i], mw[i], 1, 2'd1, f3[i], 5'd3, adr[i], 32'h55, 32'h0, 32'h0, 0, 0, lat);
            tests_run++;
            if (lat !== 1) begin
                fails++;
                $display("FAIL fault_latency[%0d]: wb after %0d cycles, required 1", i, lat);
            end
        end
        tests_run++;
        if (req_accepts !== acc0 || req_valid_cycles !== vc0) begin
            fails++;
            $display("FAIL fault_no_request: accepts=%0d valid_cycles=%0d, required %0d and %0d", req_accepts, req_valid_cycles, acc0, vc0);
        end
    endtask

    task automatic test_stall();
        int lat;
        int wb0;
        wb0 = wb_count;
        run_instr(0, 1, 0, 2'd0, 3'd2, 5'd4, 32'h0000_4000, 32'hA5A5_5A5A, 32'h0, 32'h0, 3, 0, lat);
        tests_run++;
        if (lat !== 5) begin
            fails++;
            $display("FAIL stall_store_latency: wb after %0d cycles, required 5", lat);
        end
        run_instr(1, 0, 1, 2'd1, 3'd1, 5'd6, 32'h0000_4006, 32'h0, 32'h0, 32'h9876_0000, 3, 2, lat);
        tests_run++;
        if (lat !== 8) begin
            fails++;
            $display("FAIL stall_load_latency: wb after %0d cycles, required 8", lat);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (wb_count - wb0 !== 2) begin
            fails++;
            $display("FAIL stall_wb_count: %0d beats, required 2", wb_count - wb0);
        end
    endtask

    task automatic test_random_loads();
        int lat;
        logic [2:0]  f3_set [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  f3;
        logic [31:0] adr, dat;
        int          st, dl;
        for (int i = 0; i < 16; i++) begin
            f3  = f3_set[$urandom_range(0, 4)];
            adr = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 3));
            if (f3[1:0] == 2'd1) adr[0] = 1'b0;
            if (f3[1:0] == 2'd2) adr[1:0] = 2'b00;
            dat = $urandom;
            st  = $urandom_range(0, 2);
            dl  = $urandom_range(0, 2);
            ref_rdata = dat; ref_addr = adr[1:0]; ref_f3 = f3;
            #1;
            tests_run++;
            if (ref_ext !== exp_load(dat, adr[1:0], f3)) begin
                fails++;
                $display("FAIL load_align_ref[%0d]: ext=%h, required %h", i, ref_ext, exp_load(dat, adr[1:0], f3));
            end
            run_instr(1, 0, 1, 2'd1, f3, 5'(i + 1), adr, 32'h0, 32'h0, dat, st, dl, lat);
            tests_run++;
            if (lat !== 3 + st + dl) begin
                fails++;
                $display("FAIL rand_load_latency[%0d]: wb after %0d cycles, required %0d", i, lat, 3 + st + dl);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        valid_i = 1; memren_i = 1; memwren_i = 0; regwren_i = 1; wbsel_i = 2'd1;
        funct3_i = 3'd2; rd_i = 5'd13; alu_res_i = 32'h40; pc_i = 0;
        @(negedge clk);
        valid_i = 0;
        mem_req_ready_i = 1;
        @(negedge clk);
        mem_req_ready_i = 0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ready_o !== 1'b1 || mem_req_valid_o !== 1'b0 || wb_valid_o !== 1'b0 || mem_be_o !== 4'b0 || mem_addr_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid: ready=%b req=%b wb=%b be=%b addr=%h, required 1 0 0 0000 0",
                     ready_o, mem_req_valid_o, wb_valid_o, mem_be_o, mem_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (wb_valid_o !== 1'b0 || ready_o !== 1'b1) begin
                fails++;
                $display("FAIL late_rsp_ignored: wb_valid=%b ready=%b, required 0 and 1", wb_valid_o, ready_o);
            end
        end
        mem_rsp_valid_i = 1'b0;
        run_instr(0, 0, 1, 2'd0, 3'd0, 5'd14, 32'h0000_0777, 32'h0, 32'h0, 32'h0, 0, 0, lat);
        tests_run++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL post_reset_latency: wb after %0d cycles, required 1", lat);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_store();
        test_load();
        test_fault();
        test_stall();
        test_random_loads();
        test_reset_mid();
        repeat (3) @(negedge clk);
        tests_run++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d beats outstanding, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
